ask_tx_ctrl: RTL and testbench

ASK_TX_CTRL -- requirements
Module: ask_tx_ctrl

---
 rtl/ask_pkg.sv | 20 ++
 rtl/ask_bit_timer.sv | 35 +++
 rtl/ask_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_ask_tx_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ask_pkg.sv
// Shared definitions for the ASK transmit controller: state encoding and
// parameter defaults.
package ask_pkg;

   localparam int         ASK_BIT_CYCLES_DEF = 16;
   localparam logic [7:0] ASK_PREAMBLE_DEF   = 8'hAA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } ask_state_t;

   // Counter width for a 0..n-1 count; at least one bit.
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ask_bit_timer.sv
// Bit period timer: counts 0..BIT_CYCLES-1 while run is high.
// It flags the final cycle of the period (bit_end) and the cycle before it (bit_pre).
module ask_bit_timer
   import ask_pkg::*;
#(
   parameter int BIT_CYCLES = ASK_BIT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic bit_end,
   output logic bit_pre
);

   localparam int            CW       = cnt_w(BIT_CYCLES);
   localparam logic [CW-1:0] LAST     = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(BIT_CYCLES - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   // bit_pre lets the FSM register outputs that must be valid in the final cycle.
   assign bit_end = run && (cnt == LAST);
   assign bit_pre = run && (cnt == PRE_LAST);

endmodule

// File: rtl/ask_tx_ctrl.sv
// ASK baseband transmitter: serialises bytes MSB first, then sends a guard bit.
// Define ASK_TX_PREAMBLE_EN to send PREAMBLE ahead of every frame.
module ask_tx_ctrl
   import ask_pkg::*;
#(
   parameter int         BIT_CYCLES = ASK_BIT_CYCLES_DEF,
   parameter logic [7:0] PREAMBLE   = ASK_PREAMBLE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       bb_out,
   output logic       mod_en,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   ask_state_t state;
   logic [7:0] sh;
   logic [2:0] idx;
   logic       last_q;
   logic       accept;
   logic       load;
   logic       run;
   logic       bit_end;
   logic       bit_pre;

`ifdef ASK_TX_PREAMBLE_EN
   logic [7:0] data_q;
`else
   logic       unused_pre;
   assign unused_pre = ^PREAMBLE;
`endif

   assign accept = in_ready && in_valid;
   assign load   = (state == IDLE) && accept;
   assign run    = (state != IDLE);

   ask_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .run     (run),
      .bit_end (bit_end),
      .bit_pre (bit_pre)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         sh         <= '0;
         idx        <= '0;
         last_q     <= 1'b0;
         in_ready   <= 1'b0;
         bb_out     <= 1'b0;
         mod_en     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
`ifdef ASK_TX_PREAMBLE_EN
         data_q     <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               bb_out   <= 1'b0;
               mod_en   <= 1'b0;
               busy     <= 1'b0;
               if (accept) begin
                  in_ready <= 1'b0;
                  mod_en   <= 1'b1;
                  busy     <= 1'b1;
                  idx      <= 3'd7;
                  last_q   <= in_last;
`ifdef ASK_TX_PREAMBLE_EN
                  data_q   <= in_data;
                  sh       <= PREAMBLE;
                  bb_out   <= PREAMBLE[7];
                  state    <= PRE;
`else
                  sh       <= in_data;
                  bb_out   <= in_data[7];
                  state    <= DATA;
`endif
               end
            end
`ifdef ASK_TX_PREAMBLE_EN
            PRE: begin
               if (bit_end) begin
                  if (idx == 3'd0) begin
                     state  <= DATA;
                     sh     <= data_q;
                     bb_out <= data_q[7];
                     idx    <= 3'd7;
                  end else begin
                     sh     <= sh << 1;
                     bb_out <= sh[6];
                     idx    <= idx - 3'd1;
                  end
               end
            end
`endif
            DATA: begin
               // Open the handshake window for exactly the last cycle of bit 0.
               if (bit_pre && (idx == 3'd0) && !last_q)
                  in_ready <= 1'b1;
               if (bit_end) begin
                  in_ready <= 1'b0;
                  if (idx != 3'd0) begin
                     sh     <= sh << 1;
                     bb_out <= sh[6];
                     idx    <= idx - 3'd1;
                  end else if (accept) begin
                     sh     <= in_data;
                     bb_out <= in_data[7];
                     last_q <= in_last;
                     idx    <= 3'd7;
                  end else begin
                     state    <= STOP;
                     bb_out   <= 1'b0;
                     underrun <= !last_q;
                  end
               end
            end
            STOP: begin
               if (bit_pre)
                  frame_done <= 1'b1;
               if (bit_end) begin
                  state    <= IDLE;
                  mod_en   <= 1'b0;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ask_tx_ctrl.sv
// Directed bench for ask_tx_ctrl at BIT_CYCLES=4; expected waveforms are built
// from the byte values, with the preamble prepended when ASK_TX_PREAMBLE_EN is set.
module tb_ask_tx_ctrl;

   localparam int BC = 4;
`ifdef ASK_TX_PREAMBLE_EN
   localparam int P = 8 * BC;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready, bb_out, mod_en, busy, frame_done, underrun;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ask_tx_ctrl #(.BIT_CYCLES(BC), .PREAMBLE(8'hAA)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .bb_out     (bb_out),
      .mod_en     (mod_en),
      .busy       (busy),
      .frame_done (frame_done),
      .underrun   (underrun)
   );

   // {in_ready, bb_out, mod_en, busy, frame_done, underrun}
   function automatic logic [5:0] obs();
      return {in_ready, bb_out, mod_en, busy, frame_done, underrun};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic [5:0] o, input logic [5:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, o, e);
      end
   endtask

   // Send b0 (and b1 back-to-back when two=1); optionally assert reset at cycle rst_at.
   task automatic run_frame(input string tag, input logic [7:0] b0, input logic b0_last,
                            input bit two, input logic [7:0] b1, input int rst_at);
      logic       q[$];
      logic [7:0] pa;
      int         len, rdy_k, ur_k;
      pa = 8'hAA;
      if (P != 0)
         for (int i = 7; i >= 0; i--) repeat (BC) q.push_back(pa[i]);
      for (int i = 7; i >= 0; i--) repeat (BC) q.push_back(b0[i]);
      if (two)
         for (int i = 7; i >= 0; i--) repeat (BC) q.push_back(b1[i]);
      repeat (BC) q.push_back(1'b0);
      len   = q.size();
      rdy_k = b0_last ? -1 : P + 8 * BC;
      ur_k  = (!b0_last && !two) ? P + 8 * BC + 1 : -1;

      in_valid = 1'b1; in_data = b0; in_last = b0_last;
      step();
      if (two) begin
         in_data = b1; in_last = 1'b1;
      end else begin
         in_valid = 1'b0; in_data = 8'h3C; in_last = 1'b0;
      end

      for (int k = 1; k <= len; k++) begin
         chk(tag, k, obs(), {k == rdy_k, q[k-1], 1'b1, 1'b1, k == len, k == ur_k});
         if (k == rst_at) begin
            rst = 1'b0;
            step();
            chk({tag, "_inrst"}, k + 1, obs(), 6'b000000);
            rst = 1'b1; in_valid = 1'b0;
            step();
            chk({tag, "_release"}, k + 2, obs(), 6'b100000);
            for (int j = 0; j < 40; j++) begin
               step();
               chk({tag, "_quiet"}, k + 3 + j, obs(), 6'b100000);
            end
            return;
         end
         step();
         if (k == rdy_k) in_valid = 1'b0;
      end
      chk({tag, "_idle"}, len + 1, obs(), 6'b100000);
   endtask

   initial begin
      step();
      step();
      chk("reset", 0, obs(), 6'b000000);
      rst = 1'b1;
      step();
      chk("reset_release", 0, obs(), 6'b100000);
      step();
      chk("idle", 0, obs(), 6'b100000);

      run_frame("c3_last",     8'hC3, 1'b1, 1'b0, 8'h00, 0);
      run_frame("0f_last",     8'h0F, 1'b1, 1'b0, 8'h00, 0);
      run_frame("ff_then_00",  8'hFF, 1'b0, 1'b1, 8'h00, 0);
      run_frame("a5_underrun", 8'hA5, 1'b0, 1'b0, 8'h00, 0);
      run_frame("rst_mid",     8'h5A, 1'b1, 1'b0, 8'h00, 10);
      run_frame("after_rst",   8'h81, 1'b1, 1'b0, 8'h00, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
